// File: rtl/sram_model_pkg.sv
// Shared definitions for the parametrised 1rw1r SRAM behavioural model.
package sram_model_pkg;

    // What port 1 returns when it reads the word port 0 writes in the same cycle.
    localparam int COLL_OLD = 0;
    localparam int COLL_NEW = 1;
    localparam int COLL_X   = 2;

    typedef enum logic {
        CLEAR,
        READY
    } sram_state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data pipeline for one port: one capture stage plus READ_LATENCY output stages.
// The last stage holds its word when no read completes; rst0 flushes everything to zero.
module sram_rd_pipe #(
    parameter int DATA_WIDTH   = 44,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dvalid
);

    localparam int STAGES = READ_LATENCY + 1;

    logic [DATA_WIDTH-1:0] data_q [STAGES];
    logic [STAGES-1:0]     valid_q;

    // Shift the valid bits every cycle; each data stage only loads behind a valid bit.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            // NOTE: state is updated with <= so every stage samples the pre-edge value of its neighbour.
            valid_q <= {valid_q[STAGES-2:0], rd_valid};
            if (rd_valid) begin
                data_q[0] <= rd_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign dout   = data_q[STAGES-1];
    assign dvalid = valid_q[STAGES-1];

endmodule

// File: rtl/sram_1rw1r_param_model.sv
// Parametrised 1rw1r SRAM model: array, clear-on-reset sequencer, byte-lane write
// merge, port-1 collision handling and per-port read pipelines.
module sram_1rw1r_param_model
    import sram_model_pkg::*;
#(
    parameter int  DATA_WIDTH     = 44,
    parameter int  ADDR_WIDTH     = 6,
    parameter int  WMASK_GRAN     = 8,
    parameter int  READ_LATENCY   = 1,
    parameter int  CLEAR_ON_RESET = 1,
    parameter int  COLLISION_MODE = 0,
    localparam int NUM_WMASKS     = ceil_div(DATA_WIDTH, WMASK_GRAN),
    localparam int RAM_DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dvalid1,
    output logic                  ready,
    output logic                  coll
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sram_1rw1r_param_model: READ_LATENCY must be 1 or 2");
    end
    if (COLLISION_MODE < COLL_OLD || COLLISION_MODE > COLL_X) begin : g_bad_coll_mode
        $error("sram_1rw1r_param_model: COLLISION_MODE must be 0, 1 or 2");
    end

    localparam sram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    sram_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  p0_wr, p0_rd, p1_rd, collide;
    logic [DATA_WIDTH-1:0] bit_en, merged0, rd0_word, rd1_word;
    logic                  coll_q;

    // Clear sequencer state register; reset restarts the sweep from address 0.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Clear sequencer next state: walk every address once, then open the array.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                state_d = READY;
            end
        end
    end

    assign ready   = (state_q == READY) && !rst0;
    assign p0_wr   = ready && !csb0 && !web0;
    assign p0_rd   = ready && !csb0 &&  web0;
    assign p1_rd   = ready && !csb1;
    assign collide = p0_wr && p1_rd && (addr0 == addr1);

    assign rd0_word = mem[addr0];

    // Expand the lane mask to a per-bit enable; the last lane is clipped at DATA_WIDTH.
    always_comb begin
        bit_en = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            bit_en[b] = wmask0[b / WMASK_GRAN];
        end
    end

    assign merged0 = (rd0_word & ~bit_en) | (din0 & bit_en);

    // Port 1 read word, with the configured override when port 0 writes the same address.
    always_comb begin
        rd1_word = mem[addr1];
        if (collide) begin
            case (COLLISION_MODE)
                COLL_NEW: rd1_word = merged0;
                COLL_X:   rd1_word = {DATA_WIDTH{1'bx}};
                default:  rd1_word = mem[addr1];
            endcase
        end
    end

    // Array writes: zero sweep while clearing, masked port 0 writes once ready.
    always_ff @(posedge clk0) begin
        // NOTE: the array itself has no reset branch; only the clear sweep zeroes it.
        if (!rst0) begin
            if (state_q == CLEAR) begin
                mem[clr_cnt_q] <= '0;
            end else if (p0_wr) begin
                mem[addr0] <= merged0;
            end
        end
    end

    // Collision strobe, delayed so it lines up with a single-cycle read.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            coll_q <= 1'b0;
            coll   <= 1'b0;
        end else begin
            coll_q <= collide;
            coll   <= coll_q;
        end
    end

    sram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe0 (
        .clk0    (clk0),
        .rst0    (rst0),
        .rd_valid(p0_rd),
        .rd_data (rd0_word),
        .dout    (dout0),
        .dvalid  (dvalid0)
    );

    sram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe1 (
        .clk0    (clk0),
        .rst0    (rst0),
        .rd_valid(p1_rd),
        .rd_data (rd1_word),
        .dout    (dout1),
        .dvalid  (dvalid1)
    );

endmodule

// File: tb/tb_sram_1rw1r_param_model.sv
// Directed bench for sram_1rw1r_param_model. Three instances share one set of inputs:
// a = defaults, b = READ_LATENCY 2 / new-data collisions, c = all-X collisions.
module tb_sram_1rw1r_param_model;

    logic        clk0 = 1'b0;
    logic        rst0, csb0, web0, csb1;
    logic [5:0]  wmask0, addr0, addr1;
    logic [43:0] din0;

    logic [43:0] a_dout0, a_dout1, b_dout0, b_dout1, c_dout0, c_dout1;
    logic        a_dvalid0, a_dvalid1, a_ready, a_coll;
    logic        b_dvalid0, b_dvalid1, b_ready, b_coll;
    logic        c_dvalid0, c_dvalid1, c_ready, c_coll;

    int checks = 0;
    int errors = 0;

    always #5 clk0 = ~clk0;

    sram_1rw1r_param_model u_a (
        .clk0(clk0), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(a_dout0), .dvalid0(a_dvalid0),
        .csb1(csb1), .addr1(addr1), .dout1(a_dout1), .dvalid1(a_dvalid1),
        .ready(a_ready), .coll(a_coll)
    );

    sram_1rw1r_param_model #(.READ_LATENCY(2), .COLLISION_MODE(1)) u_b (
        .clk0(clk0), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(b_dout0), .dvalid0(b_dvalid0),
        .csb1(csb1), .addr1(addr1), .dout1(b_dout1), .dvalid1(b_dvalid1),
        .ready(b_ready), .coll(b_coll)
    );

    sram_1rw1r_param_model #(.COLLISION_MODE(2)) u_c (
        .clk0(clk0), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(c_dout0), .dvalid0(c_dvalid0),
        .csb1(csb1), .addr1(addr1), .dout1(c_dout1), .dvalid1(c_dvalid1),
        .ready(c_ready), .coll(c_coll)
    );

    // Advance one posedge, then settle at the following negedge to drive and sample.
    task automatic tick();
        @(posedge clk0);
        @(negedge clk0);
    endtask

    task automatic write_word(input logic [5:0] a, input logic [43:0] d, input logic [5:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
        tick();
        csb0 = 1'b1; web0 = 1'b1;
    endtask

    // Present a read on both ports for one posedge; returns just after that posedge.
    task automatic read_both(input logic [5:0] a0, input logic [5:0] a1);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a0; csb1 = 1'b0; addr1 = a1;
        tick();
        csb0 = 1'b1; csb1 = 1'b1;
    endtask

    // Ready must rise exactly on the 64th posedge after the last posedge that saw rst0 high.
    task automatic wait_clear(input string name, input int drop_at);
        for (int i = 1; i <= 64; i++) begin
            if (i == drop_at) begin
                csb0 = 1'b0; web0 = 1'b0; addr0 = 6'd3; din0 = '1; wmask0 = '1;
                csb1 = 1'b0; addr1 = 6'd3;
            end
            tick();
            csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
            checks++;
            if ({a_ready, b_ready, c_ready, a_dvalid0, a_dvalid1, a_coll, b_dvalid0, b_dvalid1, b_coll,
                 c_dvalid0, c_dvalid1, c_coll} !== {{3{i == 64}}, 9'b0}) begin
                errors++;
                $display("FAIL %s cycle %0d: ready a/b/c=%b%b%b strobes=%b%b%b, required ready=%b strobes=0",
                         name, i, a_ready, b_ready, c_ready, a_dvalid0, a_dvalid1, a_coll, i == 64);
            end
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b1;
        repeat (3) tick();
        checks++;
        if ({a_dout0, a_dout1, a_dvalid0, a_dvalid1, a_ready, a_coll} !== '0 ||
            {b_dout0, b_dout1, b_dvalid0, b_dvalid1, b_ready, b_coll} !== '0 ||
            {c_dout0, c_dout1, c_dvalid0, c_dvalid1, c_ready, c_coll} !== '0) begin
            errors++;
            $display("FAIL reset_values: a dout0=%h dout1=%h strobes=%b%b ready=%b coll=%b, required all 0",
                     a_dout0, a_dout1, a_dvalid0, a_dvalid1, a_ready, a_coll);
        end
    endtask

    task automatic test_clear();
        rst0 = 1'b0;
        // A write to address 3 at cycle 40 lands after the sweep passed it and must be dropped.
        wait_clear("clear_timing", 40);
        read_both(6'h2A, 6'h03);
        checks++;
        if ({a_dvalid0, a_dvalid1} !== 2'b00) begin
            errors++;
            $display("FAIL clear_read_early: dvalid0/1=%b%b, required 00", a_dvalid0, a_dvalid1);
        end
        tick();
        checks++;
        if ({a_dvalid0, a_dout0, a_dvalid1, a_dout1} !== {1'b1, 44'h0, 1'b1, 44'h0}) begin
            errors++;
            $display("FAIL clear_read: dvalid0=%b dout0=%h dvalid1=%b dout1=%h, required 1/0 1/0 (drop at addr 3)",
                     a_dvalid0, a_dout0, a_dvalid1, a_dout1);
        end
    endtask

    task automatic test_masked_write();
        write_word(6'd5, 44'hFFF_FFFF_FFFF, 6'b100001);
        tick();
        checks++;
        if ({a_dvalid0, b_dvalid0, c_dvalid0} !== 3'b000) begin
            errors++;
            $display("FAIL write_no_strobe: dvalid0 a/b/c=%b%b%b, required 000", a_dvalid0, b_dvalid0, c_dvalid0);
        end
        read_both(6'd5, 6'd5);
        tick();
        checks++;
        if ({a_dvalid0, a_dout0, a_dvalid1, a_dout1} !== {1'b1, 44'hF00_0000_00FF, 1'b1, 44'hF00_0000_00FF} ||
            {b_dvalid0, b_dvalid1} !== 2'b00) begin
            errors++;
            $display("FAIL mask_lat1: dout0=%h dout1=%h strobes=%b%b b_strobes=%b%b, required F00000000FF, 11, 00",
                     a_dout0, a_dout1, a_dvalid0, a_dvalid1, b_dvalid0, b_dvalid1);
        end
        tick();
        checks++;
        if ({b_dvalid0, b_dout0, b_dvalid1, b_dout1} !== {1'b1, 44'hF00_0000_00FF, 1'b1, 44'hF00_0000_00FF} ||
            {a_dvalid0, a_dvalid1, a_dout0} !== {2'b00, 44'hF00_0000_00FF}) begin
            errors++;
            $display("FAIL mask_lat2: b dout0=%h dout1=%h strobes=%b%b a strobes=%b%b, required F00000000FF 11 / 00",
                     b_dout0, b_dout1, b_dvalid0, b_dvalid1, a_dvalid0, a_dvalid1);
        end
        write_word(6'd5, 44'h0, 6'b000000);
        write_word(6'd5, 44'h123_4567_89AB, 6'b000110);
        read_both(6'd5, 6'd5);
        tick();
        checks++;
        if ({a_dout0, a_dout1} !== {44'hF00_0067_89FF, 44'hF00_0067_89FF}) begin
            errors++;
            $display("FAIL mask_partial: dout0=%h dout1=%h, required F00006789FF", a_dout0, a_dout1);
        end
        tick();
    endtask

    task automatic test_collision();
        write_word(6'd9, 44'h123, 6'b111111);
        csb0 = 1'b0; web0 = 1'b0; addr0 = 6'd9; din0 = 44'hABC; wmask0 = 6'b111111;
        csb1 = 1'b0; addr1 = 6'd9;
        tick();
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
        checks++;
        if ({a_coll, b_coll, c_coll} !== 3'b000) begin
            errors++;
            $display("FAIL coll_early: coll a/b/c=%b%b%b, required 000", a_coll, b_coll, c_coll);
        end
        tick();
        checks++;
        if ({a_coll, a_dvalid1, a_dout1, a_dvalid0} !== {2'b11, 44'h123, 1'b0} ||
            {b_coll, b_dvalid1} !== 2'b10 || {c_coll, c_dvalid1} !== 2'b11) begin
            errors++;
            $display("FAIL coll_pulse: a coll=%b dvalid1=%b dout1=%h, b coll=%b dvalid1=%b, c coll=%b dvalid1=%b, required 1 1 123 / 1 0 / 1 1",
                     a_coll, a_dvalid1, a_dout1, b_coll, b_dvalid1, c_coll, c_dvalid1);
        end
        tick();
        checks++;
        if ({a_coll, b_coll, c_coll} !== 3'b000 || {b_dvalid1, b_dout1} !== {1'b1, 44'hABC}) begin
            errors++;
            $display("FAIL coll_new_data: coll=%b%b%b b dvalid1=%b dout1=%h, required 000 1 ABC",
                     a_coll, b_coll, c_coll, b_dvalid1, b_dout1);
        end
        read_both(6'd9, 6'd9);
        tick();
        tick();
        checks++;
        if ({a_dout0, a_dout1, c_dout1} !== {3{44'hABC}} || {b_dvalid1, b_dout1} !== {1'b1, 44'hABC}) begin
            errors++;
            $display("FAIL coll_after: a dout0=%h dout1=%h c dout1=%h b dout1=%h, required ABC",
                     a_dout0, a_dout1, c_dout1, b_dout1);
        end
    endtask

    task automatic test_no_collision();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 6'd9; csb1 = 1'b0; addr1 = 6'd9;
        tick();
        web0 = 1'b0; addr0 = 6'd10; din0 = 44'h55; wmask0 = '1;
        tick();
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
        checks++;
        if ({a_coll, b_coll, c_coll} !== 3'b000 || {a_dvalid0, a_dvalid1} !== 2'b11) begin
            errors++;
            $display("FAIL no_coll_read_read: coll=%b%b%b dvalid=%b%b, required 000 11",
                     a_coll, b_coll, c_coll, a_dvalid0, a_dvalid1);
        end
        tick();
        checks++;
        if ({a_coll, b_coll, c_coll} !== 3'b000) begin
            errors++;
            $display("FAIL no_coll_diff_addr: coll=%b%b%b, required 000", a_coll, b_coll, c_coll);
        end
    endtask

    task automatic test_back_to_back();
        logic [43:0] exp_a, exp_b;
        write_word(6'd1, 44'h111, '1);
        write_word(6'd2, 44'h222, '1);
        write_word(6'd3, 44'h333, '1);
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin
                csb1 = 1'b0; addr1 = 6'(k + 1);
            end else begin
                csb1 = 1'b1;
            end
            tick();
            exp_a = (k == 0) ? 44'hABC : 44'h111 * 44'((k > 3) ? 3 : k);
            exp_b = (k < 2)  ? 44'hABC : 44'h111 * 44'((k > 4) ? 3 : k - 1);
            checks++;
            if ({a_dvalid1, a_dout1, b_dvalid1, b_dout1} !==
                {(k >= 1 && k <= 3), exp_a, (k >= 2 && k <= 4), exp_b}) begin
                errors++;
                $display("FAIL back_to_back k=%0d: a %b/%h b %b/%h, required a %b/%h b %b/%h",
                         k, a_dvalid1, a_dout1, b_dvalid1, b_dout1,
                         (k >= 1 && k <= 3), exp_a, (k >= 2 && k <= 4), exp_b);
            end
        end
    endtask

    task automatic test_reset_inflight();
        write_word(6'd50, 44'h5A5, '1);
        read_both(6'd50, 6'd50);
        rst0 = 1'b1;
        tick();
        checks++;
        if ({a_dout0, a_dout1, a_dvalid0, a_dvalid1, a_coll} !== '0 ||
            {b_dout0, b_dout1, b_dvalid0, b_dvalid1, b_coll} !== '0 ||
            {c_dout0, c_dout1, c_dvalid0, c_dvalid1, c_coll} !== '0) begin
            errors++;
            $display("FAIL reset_inflight: a %h/%h %b%b b %h/%h %b%b, required all 0",
                     a_dout0, a_dout1, a_dvalid0, a_dvalid1, b_dout0, b_dout1, b_dvalid0, b_dvalid1);
        end
        tick();
        checks++;
        if ({b_dvalid0, b_dvalid1, a_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_inflight_lat2: b dvalid=%b%b ready=%b, required 000", b_dvalid0, b_dvalid1, a_ready);
        end
    endtask

    task automatic test_reset_mid_clear();
        rst0 = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            checks++;
            if ({a_ready, b_ready, c_ready} !== 3'b000) begin
                errors++;
                $display("FAIL mid_clear_first cycle %0d: ready=%b%b%b, required 000", i, a_ready, b_ready, c_ready);
            end
        end
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        wait_clear("mid_clear_restart", 0);
        read_both(6'd50, 6'd50);
        tick();
        checks++;
        if ({a_dvalid0, a_dout0, a_dvalid1, a_dout1} !== {1'b1, 44'h0, 1'b1, 44'h0}) begin
            errors++;
            $display("FAIL mid_clear_contents: dvalid0=%b dout0=%h dvalid1=%b dout1=%h, required 1/0 1/0",
                     a_dvalid0, a_dout0, a_dvalid1, a_dout1);
        end
    endtask

    initial begin
        rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
        wmask0 = '0; addr0 = '0; addr1 = '0; din0 = '0;
        test_reset();
        test_clear();
        test_masked_write();
        test_collision();
        test_no_collision();
        test_back_to_back();
        test_reset_inflight();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
